// File: rtl/calpoc_pkg.sv
// Shared encodings for the button calculator: operation and entry-state codes,
// plus the active-high hex-to-segment table ({g,f,e,d,c,b,a}).
package calpoc_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'd0,
      OP_XOR = 2'd1,
      OP_AND = 2'd2,
      OP_ADD = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_RES = 2'd2
   } state_e;

   // Entry 15 first so that SEG_TABLE[n] is the code for hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
      7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
      7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
      7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };

endpackage

// File: rtl/calpoc_hex7seg.sv
// Combinational hex digit to seven-segment decoder; SEG_ACTIVE_LOW inverts
// every segment for common-anode displays.
module calpoc_hex7seg
   import calpoc_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_ACTIVE_LOW ? ~SEG_TABLE[hex] : SEG_TABLE[hex];

endmodule

// File: rtl/calpoc_calc_core.sv
// Button-driven calculator core: bit-serial operand entry, four operations,
// result chaining and a registered hex seven-segment display.
module calpoc_calc_core
   import calpoc_pkg::*;
#(
   parameter int unsigned WIDTH          = 3,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_one,
   input  logic             btn_zero,
   input  logic             btn_or,
   input  logic             btn_xor,
   input  logic             btn_and,
   input  logic             btn_add,
   input  logic             btn_eq,
   input  logic             btn_clr,
   output logic [WIDTH-1:0] led_a,
   output logic [WIDTH-1:0] led_b,
   output logic [6:0]       seg,
   output logic             carry,
   output logic [1:0]       op_sel,
   output logic [1:0]       state
);

   localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];

   logic [7:0] btn_raw, btn_prev_d, btn_prev_q, btn_ev;
   logic       clr_ev, eq_ev, op_ev, digit_ev, digit_bit;
   op_e        op_new;

   state_e           state_d, state_q;
   op_e              op_d, op_q;
   logic [WIDTH-1:0] a_d, a_q, b_d, b_q, r_d, r_q;
   logic             carry_d, carry_q;
   logic [WIDTH-1:0] alu_res, disp_val;
   logic [WIDTH:0]   sum_w;
   logic [6:0]       seg_d, seg_q;

   // Press events: rising edge against the previous-value flop.
   assign btn_raw    = {btn_clr, btn_eq, btn_or, btn_xor, btn_and, btn_add, btn_one, btn_zero};
   assign btn_prev_d = btn_raw;
   assign btn_ev     = btn_raw & ~btn_prev_q;

   assign clr_ev    = btn_ev[7];
   assign eq_ev     = btn_ev[6];
   assign op_ev     = |btn_ev[5:2];
   assign digit_ev  = btn_ev[1] ^ btn_ev[0];
   assign digit_bit = btn_ev[1];

   always_comb begin
      op_new = OP_ADD;
      if (btn_ev[5])      op_new = OP_OR;
      else if (btn_ev[4]) op_new = OP_XOR;
      else if (btn_ev[3]) op_new = OP_AND;
   end

   assign sum_w = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      alu_res = sum_w[WIDTH-1:0];
      case (op_q)
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_AND:  alu_res = a_q & b_q;
         default: alu_res = sum_w[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_A;
      else        state_q <= state_d;
   end

   // Only the highest-priority event of a cycle acts; lower ones are dropped.
   always_comb begin
      state_d = state_q;
      if (clr_ev) begin
         state_d = S_A;
      end else if (eq_ev) begin
         if (state_q != S_A) state_d = S_RES;
      end else if (op_ev) begin
         state_d = S_B;
      end else if (digit_ev) begin
         if (state_q == S_RES) state_d = S_A;
      end
      if (state_q != S_A && state_q != S_B && state_q != S_RES) state_d = S_A;
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      op_d    = op_q;
      carry_d = carry_q;
      if (clr_ev) begin
         a_d     = '0;
         b_d     = '0;
         r_d     = '0;
         op_d    = OP_OR;
         carry_d = 1'b0;
      end else if (eq_ev) begin
         if (state_q != S_A) begin
            r_d     = alu_res;
            carry_d = (op_q == OP_ADD) ? sum_w[WIDTH] : 1'b0;
         end
      end else if (op_ev) begin
         op_d = op_new;
         if (state_q != S_B) begin
            b_d = '0;
         end
         if (state_q == S_RES) begin
            a_d     = r_q;
            carry_d = 1'b0;
         end
      end else if (digit_ev) begin
         case (state_q)
            S_A:     a_d = (a_q << 1) | WIDTH'(digit_bit);
            S_B:     b_d = (b_q << 1) | WIDTH'(digit_bit);
            default: begin
               a_d     = WIDTH'(digit_bit);
               b_d     = '0;
               carry_d = 1'b0;
            end
         endcase
      end
   end

   // The display follows the next state so seg updates in the same edge as the registers.
   always_comb begin
      case (state_d)
         S_A:     disp_val = a_d;
         S_B:     disp_val = b_d;
         default: disp_val = r_d;
      endcase
   end

   calpoc_hex7seg #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
   ) u_hex7seg (
      .hex(4'(disp_val)),
      .seg(seg_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         op_q       <= OP_OR;
         carry_q    <= 1'b0;
         seg_q      <= SEG_RESET;
      end else begin
         btn_prev_q <= btn_prev_d;
         a_q        <= a_d;
         b_q        <= b_d;
         r_q        <= r_d;
         op_q       <= op_d;
         carry_q    <= carry_d;
         seg_q      <= seg_d;
      end
   end

   assign led_a  = a_q;
   assign led_b  = b_q;
   assign seg    = seg_q;
   assign carry  = carry_q;
   assign op_sel = op_q;
   assign state  = state_q;

endmodule

// File: tb/tb_calpoc_calc_core.sv
// Directed, table-driven bench for calpoc_calc_core (WIDTH=3, active-high
// segments), with hand-written sequences for reset corner cases.
module tb_calpoc_calc_core;

   localparam logic [7:0] CLR  = 8'h80;
   localparam logic [7:0] EQ   = 8'h40;
   localparam logic [7:0] OR   = 8'h20;
   localparam logic [7:0] XOR  = 8'h10;
   localparam logic [7:0] AND  = 8'h08;
   localparam logic [7:0] ADD  = 8'h04;
   localparam logic [7:0] ONE  = 8'h02;
   localparam logic [7:0] ZERO = 8'h01;

   typedef struct {
      logic [7:0] btn;
      int         hold;
      logic [2:0] a;
      logic [2:0] b;
      logic [6:0] seg;
      logic       carry;
      logic [1:0] op;
      logic [1:0] st;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_one, btn_zero, btn_or, btn_xor, btn_and, btn_add, btn_eq, btn_clr;
   logic [2:0] led_a, led_b;
   logic [6:0] seg;
   logic       carry;
   logic [1:0] op_sel, state_o;

   int   nCompared = 0;
   int   nMismatched = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   calpoc_calc_core #(
      .WIDTH(3),
      .SEG_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_one(btn_one),
      .btn_zero(btn_zero),
      .btn_or(btn_or),
      .btn_xor(btn_xor),
      .btn_and(btn_and),
      .btn_add(btn_add),
      .btn_eq(btn_eq),
      .btn_clr(btn_clr),
      .led_a(led_a),
      .led_b(led_b),
      .seg(seg),
      .carry(carry),
      .op_sel(op_sel),
      .state(state_o)
   );

   task automatic setButtons(input logic [7:0] b);
      {btn_clr, btn_eq, btn_or, btn_xor, btn_and, btn_add, btn_one, btn_zero} = b;
   endtask

   // Drive at a falling edge, hold for 'hold' rising edges, release; outputs are then checked at this falling edge.
   task automatic applyStimulus(input logic [7:0] b, input int hold);
      @(negedge clk);
      setButtons(b);
      repeat (hold) @(negedge clk);
      setButtons(8'h00);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [6:0] s, input logic c, input logic [1:0] op,
                           input logic [1:0] st);
      checkOutput({tag, ".led_a"}, 8'(led_a), 8'(a));
      checkOutput({tag, ".led_b"}, 8'(led_b), 8'(b));
      checkOutput({tag, ".seg"}, 8'(seg), 8'(s));
      checkOutput({tag, ".carry"}, 8'(carry), 8'(c));
      checkOutput({tag, ".op_sel"}, 8'(op_sel), 8'(op));
      checkOutput({tag, ".state"}, 8'(state_o), 8'(st));
   endtask

   task automatic addVec(input logic [7:0] btn, input int hold, input logic [2:0] a,
                         input logic [2:0] b, input logic [6:0] s, input logic c,
                         input logic [1:0] op, input logic [1:0] st);
      vec_t v;
      v.btn = btn; v.hold = hold; v.a = a; v.b = b;
      v.seg = s; v.carry = c; v.op = op; v.st = st;
      vecs.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0;
      setButtons(8'h00);

      //      buttons     hold a  b  seg       c  op st
      addVec(ONE,        3, 1, 0, 7'h06, 0, 0, 0);
      addVec(ZERO,       3, 2, 0, 7'h5B, 0, 0, 0);
      addVec(ONE,        3, 5, 0, 7'h6D, 0, 0, 0);
      addVec(OR,         1, 5, 0, 7'h3F, 0, 0, 1);
      addVec(ZERO,       1, 5, 0, 7'h3F, 0, 0, 1);
      addVec(ONE,        1, 5, 1, 7'h06, 0, 0, 1);
      addVec(ONE,        1, 5, 3, 7'h4F, 0, 0, 1);
      addVec(EQ,         1, 5, 3, 7'h07, 0, 0, 2);
      addVec(CLR,        1, 0, 0, 7'h3F, 0, 0, 0);
      addVec(ONE,        1, 1, 0, 7'h06, 0, 0, 0);
      addVec(ZERO,       1, 2, 0, 7'h5B, 0, 0, 0);
      addVec(ONE,        1, 5, 0, 7'h6D, 0, 0, 0);
      addVec(ADD,        1, 5, 0, 7'h3F, 0, 3, 1);
      addVec(ONE,        1, 5, 1, 7'h06, 0, 3, 1);
      addVec(ONE,        1, 5, 3, 7'h4F, 0, 3, 1);
      addVec(EQ,         1, 5, 3, 7'h3F, 1, 3, 2);
      addVec(XOR,        1, 0, 0, 7'h3F, 0, 1, 1);
      addVec(ONE,        1, 0, 1, 7'h06, 0, 1, 1);
      addVec(EQ,         1, 0, 1, 7'h06, 0, 1, 2);
      addVec(EQ,         1, 0, 1, 7'h06, 0, 1, 2);
      addVec(ONE,        1, 1, 0, 7'h06, 0, 1, 0);
      addVec(OR | ADD,   1, 1, 0, 7'h3F, 0, 0, 1);
      addVec(ONE,        1, 1, 1, 7'h06, 0, 0, 1);
      addVec(ONE | ZERO, 1, 1, 1, 7'h06, 0, 0, 1);
      addVec(ONE,        1, 1, 3, 7'h4F, 0, 0, 1);
      addVec(CLR | EQ,   1, 0, 0, 7'h3F, 0, 0, 0);
      addVec(ONE,        1, 1, 0, 7'h06, 0, 0, 0);
      addVec(ONE | ZERO, 1, 1, 0, 7'h06, 0, 0, 0);
      addVec(ONE,        1, 3, 0, 7'h4F, 0, 0, 0);
      addVec(ONE,        1, 7, 0, 7'h07, 0, 0, 0);
      addVec(ONE,        1, 7, 0, 7'h07, 0, 0, 0);
      addVec(EQ,         1, 7, 0, 7'h07, 0, 0, 0);
      addVec(AND,        1, 7, 0, 7'h3F, 0, 2, 1);
      addVec(ONE,        1, 7, 1, 7'h06, 0, 2, 1);
      addVec(ONE,        1, 7, 3, 7'h4F, 0, 2, 1);
      addVec(EQ,         1, 7, 3, 7'h4F, 0, 2, 2);
      addVec(ADD,        1, 3, 0, 7'h3F, 0, 3, 1);
      addVec(ONE,        1, 3, 1, 7'h06, 0, 3, 1);
      addVec(ONE,        1, 3, 3, 7'h4F, 0, 3, 1);
      addVec(ONE,        1, 3, 7, 7'h07, 0, 3, 1);
      addVec(EQ,         1, 3, 7, 7'h5B, 1, 3, 2);

      repeat (3) @(negedge clk);
      checkAll("reset", 0, 0, 7'h3F, 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkAll("post_reset", 0, 0, 7'h3F, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].btn, vecs[i].hold);
         checkAll($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].seg,
                  vecs[i].carry, vecs[i].op, vecs[i].st);
      end

      // Asynchronous reset in the middle of entering B=2.
      applyStimulus(CLR, 1);
      applyStimulus(XOR, 1);
      applyStimulus(ONE, 1);
      applyStimulus(ZERO, 1);
      checkAll("pre_async", 0, 2, 7'h5B, 0, 1, 1);
      #2 rst_n = 1'b0;
      #1 checkAll("async_rst", 0, 0, 7'h3F, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(ONE, 1);
      applyStimulus(ZERO, 1);
      checkAll("after_async", 2, 0, 7'h5B, 0, 0, 0);

      // A button held through reset release yields exactly one event.
      @(negedge clk);
      rst_n = 1'b0;
      setButtons(ONE);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkAll("held_rst1", 1, 0, 7'h06, 0, 0, 0);
      repeat (2) @(negedge clk);
      checkAll("held_rst2", 1, 0, 7'h06, 0, 0, 0);
      setButtons(8'h00);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/calpoc_calc_core.md
Name: calpoc_calc_core

Overview:
- Parametrised, clocked button-driven calculator core; successor to the first-generation 3-bit OR/XOR calculator.
- Enters two WIDTH-bit operands bit-serially from one/zero buttons and applies one of four operations (OR, XOR, AND, ADD).
- Displays the operands on LEDs and the current value on a single hex seven-segment digit.
- Sits between the board button inputs and the LED/seven-segment outputs.
- Adds over the first generation: a clock, button edge detection, an entry state machine, result chaining and an ADD carry.

Parameters:
- WIDTH, 3, operand/result width in bits; legal range 1..4 so any value fits one hex digit.
- SEG_ACTIVE_LOW, 0, 1 inverts all seg outputs for common-anode displays.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- btn_one  input  1  shift a 1 into the operand being entered.
- btn_zero  input  1  shift a 0 into the operand being entered.
- btn_or  input  1  select OR.
- btn_xor  input  1  select XOR.
- btn_and  input  1  select AND.
- btn_add  input  1  select ADD.
- btn_eq  input  1  evaluate.
- btn_clr  input  1  clear everything.
- led_a  output  WIDTH  operand A register.
- led_b  output  WIDTH  operand B register.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- carry  output  1  ADD carry-out of the last evaluation.
- op_sel  output  2  latched operation.
- state  output  2  FSM state, for debug and the bench.

Behaviour:
- Buttons:
  - All buttons are synchronous to clk, level-high.
  - Each button has an internal previous-value flop; a press event is the cycle where the button is 1 and its previous value is 0.
  - Holding a button produces exactly one event.
  - Previous-value flops reset to 0, so a button held through reset release produces one event on the first clock.
- Encodings:
  - Operations: OR=0, XOR=1, AND=2, ADD=3.
  - States: S_A=0 (entering A), S_B=1 (entering B), S_RES=2 (showing result).
- Event priority within one cycle: clr > eq > operator > digit.
  - Among operators: OR > XOR > AND > ADD.
  - btn_one and btn_zero events in the same cycle: both ignored.
- Reset (async assert, synchronous-to-clk release): state=S_A, A=0, B=0, R=0, op_sel=OR, carry=0, seg shows "0". The same applies if reset arrives mid-entry.
- Digit shift:
  - Operand <= {operand[WIDTH-2:0], bit}; the MSB is discarded (wraps with no overflow flag).
  - For WIDTH=1, operand <= bit.
- Clear event: same register values as reset, from any state.
- S_A:
  - Digit event: shifts into A.
  - Operator event: latch op_sel, B<=0, go to S_B.
  - eq event: ignored.
- S_B:
  - Digit event: shifts into B.
  - Operator event: replaces op_sel; B is unchanged.
  - eq event:
    - R <= A op B, truncated to WIDTH.
    - carry <= bit WIDTH of A+B when op is ADD, else 0.
    - Go to S_RES.
- S_RES:
  - Digit event: A<={WIDTH-1 zeros, bit}, B<=0, carry<=0, go to S_A.
  - Operator event (chaining): A<=R, B<=0, latch op_sel, carry<=0, go to S_B.
  - eq event: re-evaluates A op B, which yields the same R.
- Display:
  - seg shows hex of A in S_A, B in S_B, R in S_RES, zero-extended to 4 bits.
  - Codes (gfedcba, active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Latency: all outputs are registered. An event in cycle n is visible on every output after the clock edge ending cycle n (one-cycle latency), seg included.

Decomposition:
- Shared package calpoc_pkg holds:
  - operation encodings (OP_OR, OP_XOR, OP_AND, OP_ADD);
  - state encodings (S_A, S_B, S_RES);
  - the 16-entry hex-to-segment constant table.
- One sub-module, calpoc_hex7seg: combinational 4-bit to 7-segment decoder, polarity set by SEG_ACTIVE_LOW.
- The core instantiates calpoc_hex7seg and registers its output.

Test Plan (WIDTH=3, SEG_ACTIVE_LOW=0):
- Press one, zero, one, each held 3 cycles -> led_a=3'b101 after the third press; seg=1101101; state=S_A. Holding does not repeat the shift.
- Then or; zero, one, one; eq -> led_b=3'b011, state=S_RES, seg=0000111 (7), carry=0, op_sel=0.
- Enter A=5, B=3 with add, then eq -> result 0 (8 mod 8), seg=0111111, carry=1. Then press xor, one, eq -> A=0, B=1, result 1, carry=0.
- Priority and simultaneity:
  - clr and eq in the same cycle during S_B -> all registers cleared, state=S_A.
  - btn_or and btn_add together in S_A -> op_sel=OR.
  - btn_one and btn_zero together -> A unchanged.
- Reset mid-entry: rst_n low asynchronously while in S_B with B=2 -> outputs go to reset values immediately without a clock; after release, a press of zero shifts into A.
- Wrap: press one four times in S_A -> led_a=3'b111. eq in S_A is ignored: state stays S_A.
